// File: rtl/gty_quad_bringup.sv
// Bring-up and supervision sequencer for one four-lane GTY quad (10GBASE-R).
// Synchronizes GT status, sequences settle/reset/done/link and re-resets on timeout.
module gty_quad_bringup #(
  parameter int unsigned PGOOD_SETTLE = 65536,
  parameter int unsigned RESET_PULSE  = 128,
  parameter int unsigned DONE_TIMEOUT = 1250000,
  parameter int unsigned LINK_TIMEOUT = 12500000,
  parameter logic [3:0]  LANE_MASK    = 4'hf
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       manual_reset,
  input  logic [3:0] pwrgood,
  input  logic [3:0] tx_resetdone,
  input  logic [3:0] rx_resetdone,
  input  logic [3:0] link_up,
  output logic       gty_reset,
  output logic       tx_clock_stable,
  output logic       rx_clock_stable,
  output logic       quad_ready,
  output logic [2:0] state,
  output logic [7:0] retry_count,
  output logic [3:0] link_up_sync
);

  localparam int unsigned MAX_AB  = (PGOOD_SETTLE > RESET_PULSE) ? PGOOD_SETTLE : RESET_PULSE;
  localparam int unsigned MAX_CD  = (DONE_TIMEOUT > LINK_TIMEOUT) ? DONE_TIMEOUT : LINK_TIMEOUT;
  localparam int unsigned MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int          CW      = $clog2(MAX_LEN + 1);

  // A timed state of length N loads N-1 so the entry cycle counts as the first cycle.
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(PGOOD_SETTLE - 1);
  localparam logic [CW-1:0] PULSE_LOAD  = CW'(RESET_PULSE - 1);
  localparam logic [CW-1:0] DONE_LOAD   = CW'(DONE_TIMEOUT - 1);
  localparam logic [CW-1:0] LINK_LOAD   = CW'(LINK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_WAIT_PGOOD = 3'd0,
    ST_SETTLE     = 3'd1,
    ST_RESET      = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_WAIT_LINK  = 3'd4,
    ST_RUN        = 3'd5
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    retry_n, retry_inc;
  logic [15:0]   sync1, sync2;
  logic          pg_ok, done_ok, link_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {link_up, rx_resetdone, tx_resetdone, pwrgood};
      sync2 <= sync1;
    end
  end

  assign pg_ok        = (sync2[3:0] == 4'hf);
  assign done_ok      = (sync2[7:4] == 4'hf) && (sync2[11:8] == 4'hf);
  assign link_ok      = ((sync2[15:12] & LANE_MASK) == LANE_MASK);
  assign link_up_sync = sync2[15:12];
  assign retry_inc    = (retry_count == 8'hff) ? 8'hff : retry_count + 8'd1;

  always_comb begin
    state_n = state_q;
    cnt_n   = (cnt == '0) ? '0 : cnt - CW'(1);
    retry_n = retry_count;
    case (state_q)
      ST_WAIT_PGOOD: begin
        if (pg_ok) begin
          state_n = ST_SETTLE;
          cnt_n   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_n = ST_RESET;
          cnt_n   = PULSE_LOAD;
        end
      end
      ST_RESET: begin
        if (cnt == '0) begin
          state_n = ST_WAIT_DONE;
          cnt_n   = DONE_LOAD;
        end
      end
      ST_WAIT_DONE: begin
        if (done_ok) begin
          state_n = ST_WAIT_LINK;
          cnt_n   = LINK_LOAD;
        end else if (cnt == '0) begin
          state_n = ST_RESET;
          cnt_n   = PULSE_LOAD;
          retry_n = retry_inc;
        end
      end
      ST_WAIT_LINK: begin
        if (link_ok) begin
          state_n = ST_RUN;
        end else if (cnt == '0) begin
          state_n = ST_RESET;
          cnt_n   = PULSE_LOAD;
          retry_n = retry_inc;
        end
      end
      ST_RUN: begin
        if (!link_ok) begin
          state_n = ST_WAIT_LINK;
          cnt_n   = LINK_LOAD;
        end
      end
      default: state_n = ST_WAIT_PGOOD;
    endcase

    // Overrides: power-good loss beats a manual request, which beats normal progress.
    if (manual_reset && (state_q inside {ST_RESET, ST_WAIT_DONE, ST_WAIT_LINK, ST_RUN})) begin
      state_n = ST_RESET;
      cnt_n   = PULSE_LOAD;
      retry_n = retry_count;
    end
    if (!pg_ok && (state_q != ST_WAIT_PGOOD)) begin
      state_n = ST_WAIT_PGOOD;
      cnt_n   = '0;
      retry_n = retry_count;
    end
  end

  // Outputs are decoded from the next state so they change on the entering edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_WAIT_PGOOD;
      cnt             <= '0;
      retry_count     <= 8'd0;
      gty_reset       <= 1'b0;
      tx_clock_stable <= 1'b0;
      rx_clock_stable <= 1'b0;
      quad_ready      <= 1'b0;
    end else begin
      state_q         <= state_n;
      cnt             <= cnt_n;
      retry_count     <= retry_n;
      gty_reset       <= (state_n == ST_RESET);
      tx_clock_stable <= (state_n inside {ST_RESET, ST_WAIT_DONE, ST_WAIT_LINK, ST_RUN});
      rx_clock_stable <= (state_n inside {ST_RESET, ST_WAIT_DONE, ST_WAIT_LINK, ST_RUN});
      quad_ready      <= (state_n == ST_RUN);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_gty_quad_bringup.sv
// Bench for gty_quad_bringup: directed vector table, corner-case sequences and
// randomized inputs checked every cycle against a cycle-age reference model.
module tb_gty_quad_bringup;

  localparam int SETTLE_N = 16;
  localparam int PULSE_N  = 8;
  localparam int DONE_N   = 100;
  localparam int LINK_N   = 200;

  logic       clk;
  logic       rst;
  logic       manual_reset;
  logic [3:0] pwrgood, tx_resetdone, rx_resetdone, link_up;

  logic       gty_reset, tx_clock_stable, rx_clock_stable, quad_ready;
  logic [2:0] state;
  logic [7:0] retry_count;
  logic [3:0] link_up_sync;

  logic       gty_reset_m, tx_clock_stable_m, rx_clock_stable_m, quad_ready_m;
  logic [2:0] state_m;
  logic [7:0] retry_count_m;
  logic [3:0] link_up_sync_m;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  gty_quad_bringup #(
    .PGOOD_SETTLE(SETTLE_N), .RESET_PULSE(PULSE_N),
    .DONE_TIMEOUT(DONE_N), .LINK_TIMEOUT(LINK_N), .LANE_MASK(4'hf)
  ) dut (
    .clk(clk), .rst(rst), .manual_reset(manual_reset), .pwrgood(pwrgood),
    .tx_resetdone(tx_resetdone), .rx_resetdone(rx_resetdone), .link_up(link_up),
    .gty_reset(gty_reset), .tx_clock_stable(tx_clock_stable),
    .rx_clock_stable(rx_clock_stable), .quad_ready(quad_ready), .state(state),
    .retry_count(retry_count), .link_up_sync(link_up_sync)
  );

  gty_quad_bringup #(
    .PGOOD_SETTLE(SETTLE_N), .RESET_PULSE(PULSE_N),
    .DONE_TIMEOUT(DONE_N), .LINK_TIMEOUT(LINK_N), .LANE_MASK(4'h1)
  ) dut_m (
    .clk(clk), .rst(rst), .manual_reset(manual_reset), .pwrgood(pwrgood),
    .tx_resetdone(tx_resetdone), .rx_resetdone(rx_resetdone), .link_up(link_up),
    .gty_reset(gty_reset_m), .tx_clock_stable(tx_clock_stable_m),
    .rx_clock_stable(rx_clock_stable_m), .quad_ready(quad_ready_m), .state(state_m),
    .retry_count(retry_count_m), .link_up_sync(link_up_sync_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase number, cycles spent in phase, retries, and input history.
  int          m_state;
  int          m_age;
  int          m_retry;
  logic [15:0] in_hist [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int phase_len(input int ph);
    case (ph)
      1: return SETTLE_N;
      2: return PULSE_N;
      3: return DONE_N;
      4: return LINK_N;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    logic [15:0] seen;
    int          nxt;
    bit          fresh;
    bit          pg_ok, done_ok, link_ok, expired;
    if (rst) begin
      m_state = 0;
      m_age   = 0;
      m_retry = 0;
      in_hist = '{16'h0, 16'h0};
      return;
    end
    seen = in_hist[0];
    in_hist.push_back({link_up, rx_resetdone, tx_resetdone, pwrgood});
    void'(in_hist.pop_front());
    pg_ok   = (seen[3:0] == 4'hf);
    done_ok = (seen[7:4] == 4'hf) && (seen[11:8] == 4'hf);
    link_ok = (seen[15:12] == 4'hf);
    expired = (m_age == phase_len(m_state));
    nxt     = m_state;
    fresh   = 1'b0;
    if (m_state != 0 && !pg_ok) nxt = 0;
    else if (manual_reset && m_state >= 2) begin
      nxt   = 2;
      fresh = 1'b1;
    end else begin
      case (m_state)
        0: if (pg_ok) nxt = 1;
        1: if (expired) nxt = 2;
        2: if (expired) nxt = 3;
        3, 4: begin
          if ((m_state == 3) ? done_ok : link_ok) nxt = m_state + 1;
          else if (expired) begin
            nxt     = 2;
            m_retry = (m_retry < 255) ? m_retry + 1 : 255;
          end
        end
        5: if (!link_ok) nxt = 4;
        default: nxt = 0;
      endcase
    end
    m_age   = (nxt != m_state || fresh) ? 1 : m_age + 1;
    m_state = nxt;
  endtask

  task automatic tick();
    logic [19:0] exp_v, act_v;
    logic        cs;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    cs    = (m_state >= 2);
    exp_v = {3'(m_state), (m_state == 2), cs, cs, (m_state == 5), 8'(m_retry), in_hist[0][15:12]};
    act_v = {state, gty_reset, tx_clock_stable, rx_clock_stable, quad_ready, retry_count, link_up_sync};
    check("model_cycle", 32'(act_v), 32'(exp_v));
  endtask

  task automatic apply_stimulus(input logic [3:0] pg, input logic [3:0] txd,
                                input logic [3:0] rxd, input logic [3:0] lnk);
    pwrgood      = pg;
    tx_resetdone = txd;
    rx_resetdone = rxd;
    link_up      = lnk;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    manual_reset = 1'b0;
    apply_stimulus(4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [2:0] st, input logic gty,
                              input logic cs, input logic qr, input logic [7:0] rc);
    check(name, 32'({state, gty_reset, tx_clock_stable, rx_clock_stable, quad_ready, retry_count}),
          32'({st, gty, cs, cs, qr, rc}));
  endtask

  typedef struct {
    logic [3:0] pg, txd, rxd, lnk;
    logic       man;
    int         n;
    logic [2:0] st;
    logic       gty, cs, qr;
    logic [7:0] rc;
  } vec_t;

  vec_t tbl [$];

  initial begin
    #2000000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  cnt, rise1, rise2, width;
    bit  saw, gty_seen;
    logic prev_gty;

    // Clean bring-up, link drop and recovery, manual reset, then power-good loss.
    tbl.push_back('{4'hf, 4'h0, 4'h0, 4'h0, 1'b0,  2, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'h0, 4'h0, 4'h0, 1'b0,  1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'h0, 4'h0, 4'h0, 1'b0, 15, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'h0, 4'h0, 4'h0, 1'b0,  1, 3'd2, 1'b1, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'h0, 4'h0, 4'h0, 1'b0,  7, 3'd2, 1'b1, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'h0, 4'h0, 4'h0, 1'b0,  1, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'hf, 4'hf, 4'h0, 1'b0,  2, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'hf, 4'hf, 4'h0, 1'b0,  1, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'hf, 4'hf, 4'hf, 1'b0,  2, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'hf, 4'hf, 4'hf, 1'b0,  1, 3'd5, 1'b0, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{4'hf, 4'hf, 4'hf, 4'hb, 1'b0,  2, 3'd5, 1'b0, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{4'hf, 4'hf, 4'hf, 4'hb, 1'b0,  1, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'hf, 4'hf, 4'hf, 1'b0,  2, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'hf, 4'hf, 4'hf, 1'b0,  1, 3'd5, 1'b0, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{4'hf, 4'hf, 4'hf, 4'hf, 1'b1,  1, 3'd2, 1'b1, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'hf, 4'hf, 4'hf, 1'b0,  7, 3'd2, 1'b1, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'hf, 4'hf, 4'hf, 1'b0,  1, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'hf, 4'hf, 4'hf, 1'b0,  1, 3'd4, 1'b0, 1'b1, 1'b0, 8'd0});
    tbl.push_back('{4'hf, 4'hf, 4'hf, 4'hf, 1'b0,  1, 3'd5, 1'b0, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{4'h0, 4'hf, 4'hf, 4'hf, 1'b0,  2, 3'd5, 1'b0, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{4'h0, 4'hf, 4'hf, 4'hf, 1'b0,  1, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0});

    rst          = 1'b1;
    manual_reset = 1'b0;
    apply_stimulus(4'h0, 4'h0, 4'h0, 4'h0);
    do_reset();
    check_output("reset_state", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    check("reset_link_sync", 32'(link_up_sync), 32'd0);

    for (int r = 0; r < tbl.size(); r++) begin
      apply_stimulus(tbl[r].pg, tbl[r].txd, tbl[r].rxd, tbl[r].lnk);
      manual_reset = tbl[r].man;
      for (int k = 0; k < tbl[r].n; k++) begin
        tick();
        manual_reset = 1'b0;
      end
      check_output($sformatf("table_row_%0d", r), tbl[r].st, tbl[r].gty, tbl[r].cs,
                   tbl[r].qr, tbl[r].rc);
    end

    // Power-good glitch at settle cycle 10 restarts a full settle with no reset pulse.
    do_reset();
    apply_stimulus(4'hf, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 3; k++) tick();
    check("glitch_enter_settle", 32'(state), 32'd1);
    for (int k = 0; k < 9; k++) tick();
    pwrgood = 4'h0;
    tick();
    pwrgood  = 4'hf;
    gty_seen = 1'b0;
    saw      = 1'b0;
    for (int k = 0; k < 10 && !saw; k++) begin
      tick();
      if (gty_reset) gty_seen = 1'b1;
      if (state == 3'd0) saw = 1'b1;
    end
    check("glitch_back_to_wait_pgood", 32'(saw), 32'd1);
    saw = 1'b0;
    for (int k = 0; k < 10 && !saw; k++) begin
      tick();
      if (state == 3'd1) saw = 1'b1;
    end
    check("glitch_resettle_start", 32'(saw), 32'd1);
    cnt = 1;
    for (int k = 0; k < 40 && state == 3'd1; k++) begin
      tick();
      if (state == 3'd1) cnt++;
      if (state == 3'd1 && gty_reset) gty_seen = 1'b1;
    end
    check("glitch_settle_length", 32'(cnt), 32'd16);
    check("glitch_no_early_reset", 32'(gty_seen), 32'd0);
    check("glitch_then_reset", 32'({state, gty_reset}), 32'({3'd2, 1'b1}));

    // pwrgood loss during RESET drops gty_reset and clock-stable on the transition edge.
    do_reset();
    apply_stimulus(4'hf, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 19; k++) tick();
    check("pgloss_in_reset", 32'(state), 32'd2);
    tick();
    pwrgood = 4'h0;
    tick();
    tick();
    check_output("pgloss_sync_delay", 3'd2, 1'b1, 1'b1, 1'b0, 8'd0);
    tick();
    check_output("pgloss_outputs_fall", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Masked lane: only lane 0 required, so the masked instance reaches RUN.
    do_reset();
    apply_stimulus(4'hf, 4'hf, 4'hf, 4'h1);
    for (int k = 0; k < 40; k++) tick();
    check("mask_run", 32'({state_m, quad_ready_m, gty_reset_m}), 32'({3'd5, 1'b1, 1'b0}));
    check("mask_full_waits", 32'({state, quad_ready}), 32'({3'd4, 1'b0}));

    // Reset-done never completes: retry every 108 cycles, saturating at 255.
    do_reset();
    apply_stimulus(4'hf, 4'hf, 4'h7, 4'h0);
    rise1    = -1;
    rise2    = -1;
    width    = 0;
    prev_gty = 1'b0;
    for (int k = 0; k < 255 * 110 + 200 && retry_count != 8'hff; k++) begin
      tick();
      if (gty_reset && !prev_gty) begin
        if (rise1 < 0) rise1 = cyc;
        else if (rise2 < 0) begin
          rise2 = cyc;
          check("timeout_first_retry", 32'(retry_count), 32'd1);
        end
      end
      if (gty_reset && rise2 < 0) width++;
      prev_gty = gty_reset;
    end
    check("timeout_pulse_width", 32'(width), 32'd8);
    check("timeout_period", 32'(rise2 - rise1), 32'd108);
    check("timeout_saturate", 32'(retry_count), 32'd255);
    for (int k = 0; k < 300; k++) tick();
    check("timeout_saturate_hold", 32'(retry_count), 32'd255);

    // Randomized inputs held for random spans, checked by the model every cycle.
    do_reset();
    for (int seg = 0; seg < 200; seg++) begin
      apply_stimulus(($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'hf,
                     ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hf,
                     ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hf,
                     ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hf);
      for (int k = 0, span = $urandom_range(1, 40); k < span; k++) begin
        manual_reset = ($urandom_range(0, 59) == 0);
        tick();
      end
      manual_reset = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
